// File: rtl/tpm_reg_arbiter.sv
// rtl/tpm_reg_arbiter.sv - SPI/firmware arbiter for a single-port TPM register RAM
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   spi_wr_i/spi_rd_i          one-cycle SPI request pulses (addr/data sampled with them)
//   spi_addr_i, spi_data_i     SPI address and write data
//   spi_rdata_o, spi_rvalid_o  SPI read data and its one-cycle valid pulse
//   fw_req_i..fw_wdata_i       firmware request (held until fw_ack_o), op, address, data
//   fw_rdata_o, fw_ack_o       firmware read data and one-cycle completion pulse
//   fw_clr_i                   clears wr_pend_o
//   mem_*                      single-port synchronous RAM port (1-cycle read latency)
//   wr_pend_o                  sticky: an SPI write landed in the window
//   ovf_o                      sticky: an SPI request was lost (reset-only clear)
module tpm_reg_arbiter #(
  parameter int                ADDR_W      = 16,
  parameter int                MEM_AW      = 6,
  parameter logic [ADDR_W-1:0] WINDOW_BASE = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_wr_i,
  input  logic              spi_rd_i,
  input  logic [ADDR_W-1:0] spi_addr_i,
  input  logic [7:0]        spi_data_i,
  output logic [7:0]        spi_rdata_o,
  output logic              spi_rvalid_o,
  input  logic              fw_req_i,
  input  logic              fw_we_i,
  input  logic [MEM_AW-1:0] fw_addr_i,
  input  logic [7:0]        fw_wdata_i,
  output logic [7:0]        fw_rdata_o,
  output logic              fw_ack_o,
  input  logic              fw_clr_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              wr_pend_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPI_RD  = 2'd1,
    FW_WAIT = 2'd2,
    FW_ACK  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // 1-deep SPI pending slot
  logic              slot_vld;
  logic              slot_we;
  logic [ADDR_W-1:0] slot_addr;
  logic [7:0]        slot_data;

  logic rd_in_win;   // window hit of the SPI read currently in SPI_RD
  logic fw_we_q;     // op of the firmware access currently in FW_WAIT

  logic spi_pulse;
  logic spi_accept;
  logic slot_in_win;
  logic spi_issue;
  logic fw_issue;

  assign spi_pulse   = spi_wr_i | spi_rd_i;
  assign slot_in_win = (slot_addr[ADDR_W-1:MEM_AW] == WINDOW_BASE[ADDR_W-1:MEM_AW]);
  // The slot can take a new pulse while its current content is being issued.
  assign spi_accept  = spi_pulse && (!slot_vld || spi_issue);

  // Next state and issue decision. A pulse arriving this cycle already counts
  // as a pending SPI access, so it blocks a firmware issue in the same cycle.
  // Issue is also suppressed while reset is asserted so mem_* read as idle.
  always_comb begin
    state_nxt   = state;
    spi_issue   = 1'b0;
    fw_issue    = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    case (state)
      IDLE: begin
        if (reset_n) begin
          if (slot_vld) begin
            spi_issue = 1'b1;
            if (!slot_we) state_nxt = SPI_RD;
          end else if (fw_req_i && !spi_pulse) begin
            fw_issue  = 1'b1;
            state_nxt = FW_WAIT;
          end
        end
      end
      SPI_RD:  state_nxt = IDLE;
      FW_WAIT: state_nxt = FW_ACK;
      FW_ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Out-of-window SPI accesses still run through the FSM but never touch RAM.
    if (spi_issue && slot_in_win) begin
      mem_en_o    = 1'b1;
      mem_we_o    = slot_we;
      mem_addr_o  = slot_addr[MEM_AW-1:0];
      mem_wdata_o = slot_data;
    end else if (fw_issue) begin
      mem_en_o    = 1'b1;
      mem_we_o    = fw_we_i;
      mem_addr_o  = fw_addr_i;
      mem_wdata_o = fw_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // SPI request capture and overflow detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_vld  <= 1'b0;
      slot_we   <= 1'b0;
      slot_addr <= '0;
      slot_data <= 8'h00;
      ovf_o     <= 1'b0;
    end else begin
      if (spi_accept) begin
        slot_vld  <= 1'b1;
        slot_we   <= spi_wr_i;   // write wins when both pulses coincide
        slot_addr <= spi_addr_i;
        slot_data <= spi_data_i;
      end else if (spi_issue) begin
        slot_vld  <= 1'b0;
      end
      if ((spi_pulse && !spi_accept) || (spi_wr_i && spi_rd_i)) ovf_o <= 1'b1;
    end
  end

  // Completion side: read data capture, valid/ack pulses, write-pending flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_in_win    <= 1'b0;
      fw_we_q      <= 1'b0;
      spi_rdata_o  <= 8'h00;
      spi_rvalid_o <= 1'b0;
      fw_rdata_o   <= 8'h00;
      fw_ack_o     <= 1'b0;
      wr_pend_o    <= 1'b0;
    end else begin
      if (spi_issue) rd_in_win <= slot_in_win;
      if (fw_issue)  fw_we_q   <= fw_we_i;

      spi_rvalid_o <= (state == SPI_RD);
      if (state == SPI_RD) spi_rdata_o <= rd_in_win ? mem_rdata_i : 8'hFF;

      fw_ack_o <= (state == FW_WAIT);
      if (state == FW_WAIT && !fw_we_q) fw_rdata_o <= mem_rdata_i;

      // A landing write takes precedence over a simultaneous clear.
      if (spi_issue && slot_we && slot_in_win) wr_pend_o <= 1'b1;
      else if (fw_clr_i)                       wr_pend_o <= 1'b0;
    end
  end

endmodule
